// File: rtl/hv_scan_rd_rsp_pkg.sv
//------------------------------------------------------------------------------
// Module   : hv_scan_rd_rsp_pkg
// Brief    : Shared HV register-scan constants and FSM state type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hv_scan_rd_rsp_pkg;

  localparam int HV_REG_AW         = 7;
  localparam int HV_REG_DW         = 8;
  localparam int HV_REG_CRC_W      = 8;
  localparam int HV_RD_TMO_CYC_DEF = 8;

  // CRC8 generator x^8 + x^2 + x + 1, MSB first, zero seed
  localparam logic [7:0] HV_CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } scan_st_e;

endpackage

`default_nettype wire

// File: rtl/hv_scan_rd_rsp_crc16to8_parallel.sv
//------------------------------------------------------------------------------
// Module   : crc16to8_parallel
// Brief    : Combinational CRC over a DIN_W-bit word, unrolled MSB-first LFSR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc16to8_parallel #(
  parameter int               DIN_W = 16,
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
  input  logic [DIN_W-1:0] i_din,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] w_crc;
  logic             w_fb;

  always_comb begin
    w_crc = '0;
    w_fb  = 1'b0;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      w_fb  = w_crc[CRC_W-1] ^ i_din[i];
      w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{w_fb}} & POLY);
    end
  end

  assign o_crc = w_crc;

endmodule

`default_nettype wire

// File: rtl/hv_scan_rd_rsp.sv
//------------------------------------------------------------------------------
// Module   : hv_scan_rd_rsp
// Brief    : Watchdog scan read responder; arbitrates against host accesses,
//            issues one register-file read and returns data + CRC8 with ack.
//            Optional macro HV_SCAN_RSP_CRC_INJ_EN adds a one-shot CRC inject.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hv_scan_rd_rsp
  import hv_scan_rd_rsp_pkg::*;
#(
  parameter int REG_AW     = hv_scan_rd_rsp_pkg::HV_REG_AW,
  parameter int REG_DW     = hv_scan_rd_rsp_pkg::HV_REG_DW,
  parameter int REG_CRC_W  = hv_scan_rd_rsp_pkg::HV_REG_CRC_W,
  parameter int RD_TMO_CYC = hv_scan_rd_rsp_pkg::HV_RD_TMO_CYC_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wdg_scan_rac_rd_req,
  input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
  output logic                 o_rac_wdg_scan_ack,
  output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
  output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
  input  logic                 i_host_acc_busy,
  output logic                 o_rf_rd_en,
  output logic [REG_AW-1:0]    o_rf_addr,
  input  logic                 i_rf_rd_vld,
  input  logic [REG_DW-1:0]    i_rf_rd_data,
  input  logic                 i_crc_inj,
  output logic                 o_rd_tmo_err
);

  localparam int c_CNT_W = $clog2(RD_TMO_CYC);
  localparam int c_DIN_W = 1 + REG_AW + REG_DW;

  scan_st_e             state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0]    addr_q, addr_d;
  logic                 rd_en_q, rd_en_d;
  logic                 ack_q, ack_d;
  logic [REG_DW-1:0]    data_q, data_d;
  logic [REG_CRC_W-1:0] crc_q, crc_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 abort_q, abort_d;

  logic                 w_abort;
  logic                 w_tmo_hit;
  logic [REG_DW-1:0]    w_crc_data;
  logic [REG_CRC_W-1:0] w_crc;
  logic [REG_CRC_W-1:0] w_crc_flip;

  // A timed-out read is checksummed as if the register returned zero
  assign w_crc_data = i_rf_rd_vld ? i_rf_rd_data : '0;
  assign w_tmo_hit  = (cnt_q == c_CNT_W'(RD_TMO_CYC - 1));
  assign w_abort    = abort_q | ~i_wdg_scan_rac_rd_req;

  crc16to8_parallel #(
    .DIN_W (c_DIN_W),
    .CRC_W (REG_CRC_W),
    .POLY  (REG_CRC_W'(HV_CRC8_POLY))
  ) u_crc (
    .i_din ({1'b1, addr_q, w_crc_data}),
    .o_crc (w_crc)
  );

`ifdef HV_SCAN_RSP_CRC_INJ_EN
  logic inj_d1_q;
  logic inj_arm_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inj_d1_q  <= 1'b0;
      inj_arm_q <= 1'b0;
    end else begin
      inj_d1_q  <= i_crc_inj;
      inj_arm_q <= (inj_arm_q & ~ack_d) | (i_crc_inj & ~inj_d1_q);
    end
  end

  assign w_crc_flip = {{(REG_CRC_W-1){1'b0}}, inj_arm_q};
`else
  logic w_unused_crc_inj;
  assign w_unused_crc_inj = i_crc_inj;
  assign w_crc_flip       = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    ack_d     = 1'b0;
    data_d    = data_q;
    crc_d     = crc_q;
    tmo_err_d = tmo_err_q;
    abort_d   = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (i_wdg_scan_rac_rd_req && !i_host_acc_busy) begin
          state_d = ST_RD;
          addr_d  = i_wdg_scan_rac_addr;
          rd_en_d = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        abort_d = w_abort;
        if (i_rf_rd_vld) begin
          state_d = w_abort ? ST_IDLE : ST_RSP;
          if (!w_abort) begin
            ack_d  = 1'b1;
            data_d = i_rf_rd_data;
            crc_d  = w_crc ^ w_crc_flip;
          end
        end else if (w_tmo_hit) begin
          state_d   = w_abort ? ST_IDLE : ST_RSP;
          tmo_err_d = 1'b1;
          if (!w_abort) begin
            ack_d  = 1'b1;
            data_d = '0;
            crc_d  = ~w_crc ^ w_crc_flip;
          end
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      data_q    <= '0;
      crc_q     <= '0;
      tmo_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      tmo_err_q <= tmo_err_d;
      abort_q   <= abort_d;
    end
  end

  assign o_rac_wdg_scan_ack  = ack_q;
  assign o_rac_wdg_scan_data = data_q;
  assign o_rac_wdg_scan_crc  = crc_q;
  assign o_rf_rd_en          = rd_en_q;
  assign o_rf_addr           = addr_q;
  assign o_rd_tmo_err        = tmo_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hv_scan_rd_rsp.sv
//------------------------------------------------------------------------------
// Module   : tb_hv_scan_rd_rsp
// Brief    : Scoreboard bench for hv_scan_rd_rsp (optionally HV_SCAN_RSP_CRC_INJ_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hv_scan_rd_rsp;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       req;
  logic [6:0] addr;
  logic       ack;
  logic [7:0] rsp_data;
  logic [7:0] rsp_crc;
  logic       busy;
  logic       rd_en;
  logic [6:0] rf_addr;
  logic       vld;
  logic [7:0] rf_data;
  logic       crc_inj;
  logic       tmo_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ack_cnt  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] crc;
  } rsp_t;

  rsp_t sb_q[$];

  always #5 i_clk = ~i_clk;

  hv_scan_rd_rsp u_dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_wdg_scan_rac_rd_req (req),
    .i_wdg_scan_rac_addr   (addr),
    .o_rac_wdg_scan_ack    (ack),
    .o_rac_wdg_scan_data   (rsp_data),
    .o_rac_wdg_scan_crc    (rsp_crc),
    .i_host_acc_busy       (busy),
    .o_rf_rd_en            (rd_en),
    .o_rf_addr             (rf_addr),
    .i_rf_rd_vld           (vld),
    .i_rf_rd_data          (rf_data),
    .i_crc_inj             (crc_inj),
    .o_rd_tmo_err          (tmo_err)
  );

  // CRC8 (poly 0x107) as polynomial long division of {1, addr, data} * x^8
  function automatic logic [7:0] crc_model(input logic [6:0] a, input logic [7:0] d);
    logic [23:0] r;
    r = {1'b1, a, d, 8'h00};
    for (int i = 23; i >= 8; i--)
      if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && ack) begin
      ack_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("ack_data", {24'd0, rsp_data}, {24'd0, e.data});
        chk("ack_crc",  {24'd0, rsp_crc},  {24'd0, e.crc});
      end
    end
  end

  // One full request; lat=0 means the register file never answers.
  task automatic serve(input string nm, input logic [6:0] a, input int lat, input logic [7:0] d,
                       input int busy_cyc, input int exp_rd, input int exp_ack, input logic [7:0] flip);
    int   rd_at;
    int   ack_at;
    rsp_t e;
    e.data = (lat == 0) ? 8'h00 : d;
    e.crc  = ((lat == 0) ? ~crc_model(a, 8'h00) : crc_model(a, d)) ^ flip;
    sb_q.push_back(e);
    req    = 1'b1;
    addr   = a;
    busy   = (busy_cyc > 0);
    rd_at  = -1;
    ack_at = -1;
    for (int t = 1; t <= 40 && ack_at < 0; t++) begin
      tick();
      busy = (t < busy_cyc);
      if (rd_en && rd_at < 0) rd_at = t;
      if (rd_at >= 0 && lat > 0 && t == rd_at + lat) begin
        vld     = 1'b1;
        rf_data = d;
      end else begin
        vld = 1'b0;
      end
      if (ack) ack_at = t;
    end
    req  = 1'b0;
    vld  = 1'b0;
    busy = 1'b0;
    chk({nm, "_rd_cycle"},  rd_at,  exp_rd);
    chk({nm, "_ack_cycle"}, ack_at, exp_ack);
    tick();
    tick();
  endtask

  initial begin
    int acks_before;
    i_rst_n = 1'b0;
    req     = 1'b0;
    addr    = '0;
    busy    = 1'b0;
    vld     = 1'b0;
    rf_data = '0;
    crc_inj = 1'b0;
    tick();
    tick();
    chk("rst_ack",   ack,      1'b0);
    chk("rst_data",  rsp_data, 8'h00);
    chk("rst_crc",   rsp_crc,  8'h00);
    chk("rst_rd_en", rd_en,    1'b0);
    chk("rst_addr",  rf_addr,  7'h00);
    chk("rst_tmo",   tmo_err,  1'b0);
    i_rst_n = 1'b1;
    tick();

    serve("basic", 7'h50, 1, 8'hA5, 0, 1, 3, 8'h00);
    serve("lat3",  7'h12, 3, 8'h5A, 0, 1, 5, 8'h00);
    serve("busy",  7'h01, 1, 8'hC3, 5, 6, 8, 8'h00);
    chk("tmo_clear", tmo_err, 1'b0);

    serve("tmo", 7'h7F, 0, 8'h00, 0, 1, 10, 8'h00);
    chk("tmo_set", tmo_err, 1'b1);
    serve("post_tmo", 7'h2A, 1, 8'hFF, 0, 1, 3, 8'h00);
    chk("tmo_sticky", tmo_err, 1'b1);

    // Request withdrawn while waiting for the register file: no ack expected
    acks_before = ack_cnt;
    req  = 1'b1;
    addr = 7'h40;
    tick();
    chk("abort_rd_en", rd_en, 1'b1);
    tick();
    req = 1'b0;
    tick();
    vld     = 1'b1;
    rf_data = 8'h3C;
    tick();
    vld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_ack", ack_cnt, acks_before);
    serve("post_abort", 7'h41, 2, 8'h96, 0, 1, 4, 8'h00);

`ifdef HV_SCAN_RSP_CRC_INJ_EN
    crc_inj = 1'b1;
    tick();
    crc_inj = 1'b0;
    tick();
    serve("inj_first",  7'h05, 1, 8'h11, 0, 1, 3, 8'h01);
    serve("inj_second", 7'h06, 1, 8'h22, 0, 1, 3, 8'h00);
`endif

    // Asynchronous reset while the read is outstanding
    req  = 1'b1;
    addr = 7'h22;
    tick();
    tick();
    #2;
    i_rst_n = 1'b0;
    req     = 1'b0;
    #1;
    chk("mid_rst_ack",   ack,      1'b0);
    chk("mid_rst_data",  rsp_data, 8'h00);
    chk("mid_rst_crc",   rsp_crc,  8'h00);
    chk("mid_rst_rd_en", rd_en,    1'b0);
    chk("mid_rst_addr",  rf_addr,  7'h00);
    chk("mid_rst_tmo",   tmo_err,  1'b0);
    tick();
    i_rst_n = 1'b1;
    tick();
    serve("post_rst", 7'h33, 1, 8'h6E, 0, 1, 3, 8'h00);
    chk("rf_addr_latched", rf_addr, 7'h33);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
